// File: rtl/hyperbus_cfg_regs.sv
// HyperBus controller configuration register file: word-addressed register bus,
// writes deferred until the controller is idle (bounded wait), registered cfg_o.
module hyperbus_cfg_regs #(
  parameter int unsigned NumPhys     = 2,
  parameter logic [31:0] RstChipBase = 32'h0
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_i,
  input  logic [31:0] reg_addr_i,
  input  logic        reg_write_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [3:0]  reg_wstrb_i,
  input  logic        reg_valid_i,
  output logic [31:0] reg_rdata_o,
  output logic        reg_ready_o,
  output logic        reg_error_o,
  input  logic        ctl_idle_i,
  output logic [70:0] cfg_o,
  output logic        cfg_update_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic PhysRst = (NumPhys == 2) ? 1'b1 : 1'b0;
  localparam logic [3:0] IdxChipBase = 4'd11;

  state_t      state;
  logic [9:0]  wait_cnt;
  logic [3:0]  pend_idx;
  logic [31:0] pend_wdata;
  logic [3:0]  pend_wstrb;

  logic [3:0]  t_latency_access;
  logic        en_latency_additional;
  logic [15:0] t_burst_max;
  logic [3:0]  t_read_write_recovery;
  logic [3:0]  t_rx_clk_delay;
  logic [3:0]  t_tx_clk_delay;
  logic [4:0]  address_mask_msb;
  logic        address_space;
  logic        phys_in_use;
  logic        which_phy;
  logic [3:0]  t_csh_cycles;
  // Not exposed through the register map; held at zero.
  logic [25:0] timeout;

  assign timeout = '0;

  assign cfg_o = {t_latency_access, en_latency_additional, t_burst_max,
                  t_read_write_recovery, t_rx_clk_delay, t_tx_clk_delay,
                  address_mask_msb, address_space, phys_in_use, which_phy,
                  t_csh_cycles, timeout};

  logic [31:0] word [16];
  logic [3:0]  req_idx;
  logic        req_unmapped;
  logic        req_bad_write;
  logic [3:0]  sel_idx;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic [31:0] commit_word;
  logic        unused_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] m;
    m = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
    end
    return m;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) word[i] = '0;
    word[0]  = {28'd0, t_latency_access};
    word[1]  = {31'd0, en_latency_additional};
    word[2]  = {16'd0, t_burst_max};
    word[3]  = {28'd0, t_read_write_recovery};
    word[4]  = {28'd0, t_rx_clk_delay};
    word[5]  = {28'd0, t_tx_clk_delay};
    word[6]  = {27'd0, address_mask_msb};
    word[7]  = {31'd0, address_space};
    word[8]  = {31'd0, phys_in_use};
    word[9]  = {31'd0, which_phy};
    word[10] = {28'd0, t_csh_cycles};
    word[11] = RstChipBase;
  end

  assign req_idx       = reg_addr_i[5:2];
  assign req_unmapped  = (|reg_addr_i[31:6]) || (req_idx > IdxChipBase);
  assign req_bad_write = req_unmapped || (req_idx == IdxChipBase);

  // A commit from IDLE uses the live bus; from WAIT it uses the captured request.
  assign sel_idx     = (state == ST_WAIT) ? pend_idx   : req_idx;
  assign sel_wdata   = (state == ST_WAIT) ? pend_wdata : reg_wdata_i;
  assign sel_wstrb   = (state == ST_WAIT) ? pend_wstrb : reg_wstrb_i;
  assign commit_word = merge_bytes(word[sel_idx], sel_wdata, sel_wstrb);

  assign unused_bits = ^{reg_addr_i[1:0], commit_word[31:16]};

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state                 <= ST_IDLE;
      wait_cnt              <= '0;
      pend_idx              <= '0;
      pend_wdata            <= '0;
      pend_wstrb            <= '0;
      reg_rdata_o           <= '0;
      reg_ready_o           <= 1'b0;
      reg_error_o           <= 1'b0;
      cfg_update_o          <= 1'b0;
      t_latency_access      <= 4'd6;
      en_latency_additional <= 1'b1;
      t_burst_max           <= 16'd350;
      t_read_write_recovery <= 4'd6;
      t_rx_clk_delay        <= 4'd8;
      t_tx_clk_delay        <= 4'd8;
      address_mask_msb      <= 5'd25;
      address_space         <= 1'b0;
      phys_in_use           <= PhysRst;
      which_phy             <= 1'b0;
      t_csh_cycles          <= 4'd1;
    end else begin
      reg_rdata_o  <= '0;
      reg_ready_o  <= 1'b0;
      reg_error_o  <= 1'b0;
      cfg_update_o <= 1'b0;

      if (((state == ST_IDLE) && reg_valid_i && reg_write_i && !req_bad_write && ctl_idle_i) ||
          ((state == ST_WAIT) && reg_valid_i && ctl_idle_i)) begin
        case (sel_idx)
          4'd0:  t_latency_access      <= commit_word[3:0];
          4'd1:  en_latency_additional <= commit_word[0];
          4'd2:  t_burst_max           <= commit_word[15:0];
          4'd3:  t_read_write_recovery <= commit_word[3:0];
          4'd4:  t_rx_clk_delay        <= commit_word[3:0];
          4'd5:  t_tx_clk_delay        <= commit_word[3:0];
          4'd6:  address_mask_msb      <= commit_word[4:0];
          4'd7:  address_space         <= commit_word[0];
          4'd8:  if (NumPhys == 2) phys_in_use <= commit_word[0];
          4'd9:  if (NumPhys == 2) which_phy   <= commit_word[0];
          4'd10: t_csh_cycles          <= commit_word[3:0];
          default: ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (reg_valid_i) begin
            if (!reg_write_i) begin
              reg_rdata_o <= req_unmapped ? '0 : word[req_idx];
              reg_error_o <= req_unmapped;
              reg_ready_o <= 1'b1;
              state       <= ST_RESP;
            end else if (req_bad_write) begin
              reg_error_o <= 1'b1;
              reg_ready_o <= 1'b1;
              state       <= ST_RESP;
            end else if (ctl_idle_i) begin
              reg_ready_o  <= 1'b1;
              cfg_update_o <= 1'b1;
              state        <= ST_RESP;
            end else begin
              pend_idx   <= req_idx;
              pend_wdata <= reg_wdata_i;
              pend_wstrb <= reg_wstrb_i;
              wait_cnt   <= '0;
              state      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!reg_valid_i) begin
            state <= ST_IDLE;
          end else if (ctl_idle_i) begin
            reg_ready_o  <= 1'b1;
            cfg_update_o <= 1'b1;
            state        <= ST_RESP;
          end else if (wait_cnt == '1) begin
            reg_ready_o <= 1'b1;
            reg_error_o <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
